// File: rtl/pipelined_flit_adder_if.sv
// Flit handshake bundle for the pipelined adder: injector side (in_*) and sink side (out_*).
// The adder plugs into the slave modport; injector/sink models use master.
interface pipelined_flit_adder_if #(
    parameter int N = 18
);
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [N-1:0] input1;
    logic [N-1:0] input2;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [N-1:0] sum;
    logic         cout;

    modport master (
        output in_valid, in_last, input1, input2, out_ready,
        input  in_ready, out_valid, out_last, sum, cout
    );

    modport slave (
        input  in_valid, in_last, input1, input2, out_ready,
        output in_ready, out_valid, out_last, sum, cout
    );
endinterface

// File: rtl/pipelined_flit_adder.sv
// N-bit adder split into SEGS carry-chained pipeline segments with valid/ready flow control,
// a packet-end marker, and saturating flit/packet/output-toggle statistics.
module pipelined_flit_adder #(
    parameter int N     = 18,
    parameter int SEGS  = 3,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_flit_adder_if.slave bus,
    input  logic                  stats_clr,
    output logic [CNT_W-1:0]      flit_cnt,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      toggle_cnt
);
    localparam int SEG_W = N / SEGS;
    localparam int POP_W = $clog2(N + 1);

    logic [SEGS-1:0]        valid_q, valid_d;
    logic [SEGS-1:0]        last_q, last_d;
    logic [SEGS-1:0]        carry_q, carry_d;
    logic [SEGS-1:0][N-1:0] a_q, a_d;
    logic [SEGS-1:0][N-1:0] b_q, b_d;
    logic [SEGS-1:0][N-1:0] s_q, s_d;

    logic [N-1:0]     prev_sum_q, prev_sum_d;
    logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;

    logic             en;
    logic             fire;
    logic [SEG_W:0]   seg_t;
    logic [POP_W-1:0] diff_pop;

    function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] x,
                                               input logic [SEG_W-1:0] y,
                                               input logic             c);
        return {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, c};
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [N-1:0] x);
        logic [POP_W-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            p = p + POP_W'(x[i]);
        end
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] x,
                                                 input logic [CNT_W-1:0] y);
        logic [CNT_W:0] t;
        t = {1'b0, x} + {1'b0, y};
        return t[CNT_W] ? {CNT_W{1'b1}} : t[CNT_W-1:0];
    endfunction

    // Whole pipe moves in lockstep: a stalled output freezes every stage.
    always_comb begin
        en      = !valid_q[SEGS-1] || bus.out_ready;
        valid_d = valid_q;
        last_d  = last_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        seg_t   = '0;
        if (en) begin
            seg_t                 = seg_add(bus.input1[SEG_W-1:0], bus.input2[SEG_W-1:0], 1'b0);
            a_d[0]                = bus.input1;
            b_d[0]                = bus.input2;
            s_d[0]                = '0;
            s_d[0][SEG_W-1:0]     = seg_t[SEG_W-1:0];
            carry_d[0]            = seg_t[SEG_W];
            valid_d[0]            = bus.in_valid;
            last_d[0]             = bus.in_valid & bus.in_last;
            for (int k = 1; k < SEGS; k++) begin
                seg_t = seg_add(a_q[k-1][k*SEG_W +: SEG_W], b_q[k-1][k*SEG_W +: SEG_W],
                                carry_q[k-1]);
                a_d[k]                    = a_q[k-1];
                b_d[k]                    = b_q[k-1];
                s_d[k]                    = s_q[k-1];
                s_d[k][k*SEG_W +: SEG_W]  = seg_t[SEG_W-1:0];
                carry_d[k]                = seg_t[SEG_W];
                valid_d[k]                = valid_q[k-1];
                last_d[k]                 = last_q[k-1];
            end
        end
    end

    // A clear wins over a coincident transfer, but the toggle reference still tracks it.
    always_comb begin
        fire         = valid_q[SEGS-1] && bus.out_ready;
        diff_pop     = popcount(s_q[SEGS-1] ^ prev_sum_q);
        prev_sum_d   = prev_sum_q;
        flit_cnt_d   = flit_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        toggle_cnt_d = toggle_cnt_q;
        if (fire) begin
            prev_sum_d = s_q[SEGS-1];
        end
        if (stats_clr) begin
            flit_cnt_d   = '0;
            pkt_cnt_d    = '0;
            toggle_cnt_d = '0;
        end else if (fire) begin
            flit_cnt_d   = sat_add(flit_cnt_q, CNT_W'(1));
            pkt_cnt_d    = sat_add(pkt_cnt_q, CNT_W'(last_q[SEGS-1]));
            toggle_cnt_d = sat_add(toggle_cnt_q, CNT_W'(diff_pop));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            last_q       <= '0;
            carry_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            s_q          <= '0;
            prev_sum_q   <= '0;
            flit_cnt_q   <= '0;
            pkt_cnt_q    <= '0;
            toggle_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            last_q       <= last_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            s_q          <= s_d;
            prev_sum_q   <= prev_sum_d;
            flit_cnt_q   <= flit_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    // Operand segments already folded into the sum are carried but never read again.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a_q, b_q};

    assign bus.in_ready  = en;
    assign bus.out_valid = valid_q[SEGS-1];
    assign bus.out_last  = last_q[SEGS-1];
    assign bus.sum       = s_q[SEGS-1];
    assign bus.cout      = carry_q[SEGS-1];
    assign flit_cnt      = flit_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign toggle_cnt    = toggle_cnt_q;
endmodule

// File: tb/tb_pipelined_flit_adder.sv
// Directed bench for pipelined_flit_adder: carries, streaming packets, backpressure,
// toggle statistics and mid-flight reset, with an in-order scoreboard on the output.
module tb_pipelined_flit_adder;
    localparam int N     = 18;
    localparam int SEGS  = 3;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stats_clr = 1'b0;
    logic [CNT_W-1:0] flit_cnt, pkt_cnt, toggle_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int txn      = 0;

    logic [N+1:0] exp_q[$];
    logic [N+1:0] exp_v;
    logic [N-1:0] bp_a[8];
    logic [N-1:0] bp_b[8];

    pipelined_flit_adder_if #(.N(N)) bus ();

    pipelined_flit_adder #(.N(N), .SEGS(SEGS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .stats_clr  (stats_clr),
        .flit_cnt   (flit_cnt),
        .pkt_cnt    (pkt_cnt),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {last, cout, sum}.
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic l);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {l, s};
    endfunction

    // Transfers are sampled mid-cycle, i.e. the values about to be taken on the next edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", {46'd0, bus.out_last, bus.cout, bus.sum}, 64'h0);
                end else begin
                    logic [N+1:0] e;
                    e = exp_q.pop_front();
                    check("sb_sum", bus.sum, e[N-1:0]);
                    check("sb_cout", bus.cout, e[N]);
                    check("sb_last", bus.out_last, e[N+1]);
                    txn++;
                    $display("txn %0d sum=%05h cout=%0b last=%0b", txn, bus.sum, bus.cout,
                             bus.out_last);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.input1, bus.input2, bus.in_last));
            end
        end
    end

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic l);
        bus.in_valid = 1'b1;
        bus.input1   = a;
        bus.input2   = b;
        bus.in_last  = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns at the falling edge where out_valid is first seen; n counts edges since accept.
    task automatic wait_valid(output int n);
        n = 1;
        forever begin
            @(negedge clk);
            if (bus.out_valid) break;
            n++;
            if (n > 20) begin
                check("wait_valid_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.input1    = '0;
        bus.input2    = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = N'(32'h01234 + i * 32'h0AB1D);
            bp_b[i] = N'(32'h3F0F0 - i * 32'h00777);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_sum", bus.sum, '0);
        check("rst_flit_cnt", flit_cnt, '0);
        check("rst_pkt_cnt", pkt_cnt, '0);
        check("rst_toggle_cnt", toggle_cnt, '0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", bus.in_ready, 1'b1);

        // Full-width carry out
        send(18'h3FFFF, 18'h00001, 1'b1);
        wait_valid(n);
        check("carry_latency", n, 3);
        check("carry_sum", bus.sum, 18'h00000);
        check("carry_cout", bus.cout, 1'b1);
        check("carry_last", bus.out_last, 1'b1);
        @(posedge clk);
        #1;
        check("carry_flit_cnt", flit_cnt, 1);
        check("carry_pkt_cnt", pkt_cnt, 1);
        check("carry_drained", bus.out_valid, 1'b0);

        // Carries across one and two segment boundaries
        send(18'h0003F, 18'h00001, 1'b0);
        wait_valid(n);
        check("seg1_sum", bus.sum, 18'h00040);
        check("seg1_cout", bus.cout, 1'b0);
        @(posedge clk);
        #1;
        send(18'h00FFF, 18'h00001, 1'b0);
        wait_valid(n);
        check("seg2_sum", bus.sum, 18'h01000);
        check("seg2_cout", bus.cout, 1'b0);
        @(posedge clk);
        #1;

        // Streaming: 10 packets x 20 flits, 7 idle cycles between packets
        stats_clr = 1'b1;
        idle(1);
        stats_clr = 1'b0;
        check("clr_flit_cnt", flit_cnt, 0);
        for (int p = 0; p < 10; p++) begin
            for (int f = 0; f < 20; f++) begin
                send(N'((p * 20 + f) * 32'd5171 + 32'd777),
                     N'(((p * 20 + f) * 32'd9973) ^ 32'h2AAAA), f == 19);
            end
            idle(7);
        end
        idle(5);
        check("stream_flit_cnt", flit_cnt, 200);
        check("stream_pkt_cnt", pkt_cnt, 10);
        check("stream_queue_empty", exp_q.size(), 0);

        // Backpressure: stall for 4 cycles with flit 2 at the output
        for (int i = 0; i < 5; i++) begin
            send(bp_a[i], bp_b[i], i == 2);
        end
        exp_v         = model(bp_a[2], bp_b[2], 1'b1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.input1    = bp_a[5];
        bus.input2    = bp_b[5];
        bus.in_last   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_sum_hold", bus.sum, exp_v[N-1:0]);
            check("bp_last_hold", bus.out_last, 1'b1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        send(bp_a[6], bp_b[6], 1'b0);
        send(bp_a[7], bp_b[7], 1'b1);
        idle(5);
        check("bp_queue_empty", exp_q.size(), 0);
        check("bp_flit_cnt", flit_cnt, 208);

        // Toggle counting from a fresh reset
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(18'h00000, 18'h00000, 1'b0);
        send(18'h3FF00, 18'h00000, 1'b0);
        send(18'h3FFFC, 18'h00000, 1'b0);
        idle(4);
        check("tog_cnt_16", toggle_cnt, 16);
        check("tog_flit_cnt", flit_cnt, 3);
        send(18'h00000, 18'h00000, 1'b0);
        wait_valid(n);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        check("clr_fire_flit_cnt", flit_cnt, 0);
        check("clr_fire_pkt_cnt", pkt_cnt, 0);
        check("clr_fire_toggle_cnt", toggle_cnt, 0);
        send(18'h00003, 18'h00000, 1'b1);
        idle(4);
        check("tog_after_clr", toggle_cnt, 2);
        check("flit_after_clr", flit_cnt, 1);
        check("pkt_after_clr", pkt_cnt, 1);

        // Reset with three flits in flight
        send(18'h00001, 18'h00002, 1'b0);
        send(18'h00003, 18'h00004, 1'b0);
        send(18'h00005, 18'h00006, 1'b1);
        check("pre_rst_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", bus.out_valid, 1'b0);
        check("async_rst_sum", bus.sum, '0);
        check("async_rst_flit_cnt", flit_cnt, 0);
        check("async_rst_toggle_cnt", toggle_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_output", bus.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        send(18'h00007, 18'h00008, 1'b1);
        wait_valid(n);
        check("post_rst_latency", n, 3);
        check("post_rst_sum", bus.sum, 18'h0000F);
        @(posedge clk);
        #1;
        idle(2);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_flit_cnt", flit_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_flit_adder.md
Name: pipelined_flit_adder

Overview:
- Parametrised, pipelined successor to the combinational flit adder used for energy characterisation.
- Splits an N-bit add into SEGS carry-chained pipeline segments, with a valid/ready handshake on both sides.
- Carries a packet-end marker through the pipe.
- Keeps on-chip activity statistics: accepted flits, packets and output bit toggles, used as a switching-energy proxy.
- Sits between a flit injector and a sink in the link/NoC characterisation benches.

Parameters:
- N, 18, operand and sum width in bits; must be a multiple of SEGS.
- SEGS, 3, number of pipeline segments; SEG_W = N/SEGS bits each; pipeline latency = SEGS cycles.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input flit valid.
- in_ready  out  1  pipeline can accept a flit this cycle.
- in_last  in  1  flit is the last of its packet.
- input1  in  N  operand A.
- input2  in  N  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result this cycle.
- out_last  out  1  in_last of the flit now at the output.
- sum  out  N  (input1+input2) mod 2^N.
- cout  out  1  carry out of bit N-1.
- stats_clr  in  1  synchronous clear of all statistics counters.
- flit_cnt  out  CNT_W  output flits transferred (out_valid & out_ready).
- pkt_cnt  out  CNT_W  output transfers with out_last=1.
- toggle_cnt  out  CNT_W  cumulative Hamming distance between consecutive transferred sum values.

Behaviour:
- Reset (async, rst=1): all stage valid bits, stage data, sum, cout, out_last, previous-sum register and counters go to 0. in_ready reads 1 as soon as rst deasserts. Flits in flight are discarded; no partial result ever emerges.
- Global advance: en = !out_valid | out_ready; in_ready = en. When en=0 every stage holds, and sum, cout and out_last stay stable.
- Accept: an input transfer occurs on a cycle with in_valid & in_ready. Stage 0 then captures:
  - A[SEG_W-1:0] + B[SEG_W-1:0] with carry-in 0;
  - the remaining upper operand segments and in_last;
  - valid=1.
- When en=1 and in_valid=0, stage 0 loads valid=0 (bubble).
- Stage k (1..SEGS-1):
  - adds operand segment k using the registered carry from stage k-1;
  - forwards lower sum segments already computed and upper operand segments still pending;
  - propagates the valid and last bits.
- Last stage outputs drive sum, cout, out_last and out_valid.
- Latency: a flit accepted at edge t is visible on out_valid at edge t+SEGS-1, absent backpressure. SEGS=1 degenerates to a single registered adder. Throughput is 1 flit/cycle.
- Bubbles are not squeezed out; the pipeline advances only under en. Result order equals acceptance order, with no loss or duplication.
- Output transfer: fire = out_valid & out_ready. On fire:
  - flit_cnt += 1;
  - pkt_cnt += out_last;
  - toggle_cnt += popcount(sum ^ prev_sum);
  - prev_sum <= sum.
- Counters saturate at 2^CNT_W-1 and never wrap.
- stats_clr: all three counters go to 0 on that cycle and a simultaneous fire is not counted. prev_sum is still updated on such a fire, and stats_clr never clears prev_sum.
- in_last with in_valid=0 is ignored.

Test Plan:
- Carry out: N=18, SEGS=3, input1=18'h3FFFF, input2=18'h00001, out_ready=1 -> 3 cycles later out_valid=1, sum=18'h00000, cout=1, flit_cnt=1.
- Segment-boundary carry: input1=18'h0003F, input2=18'h00001 -> sum=18'h00040, cout=0; input1=18'h00FFF, input2=18'h00001 -> sum=18'h01000, carry crossing two segments, result correct.
- Streaming packets: 10 packets of 20 back-to-back flits (in_last on the 20th), 7 idle cycles between packets, out_ready=1 -> 200 fires, each sum matches the model at latency 3, flit_cnt=200, pkt_cnt=10.
- Backpressure: out_ready=0 for 4 cycles mid-stream -> in_ready=0 on those cycles, sum/out_last held stable, sequence afterward continues with no gap-fill, loss or duplicate.
- Toggle counting: after reset, transfer sums 18'h00000, 18'h3FF00, 18'h3FFFC -> toggle_cnt=0+10+6=16; then stats_clr together with a fire of 18'h00000 -> all counters 0, next fire of 18'h00003 -> toggle_cnt=2.
- Reset mid-operation: assert rst while 3 flits are in flight -> out_valid=0 immediately (async), counters 0, no stale result after rst deasserts; first post-reset flit appears after exactly 3 cycles.
